// File: rtl/ps2_mouse_master_sm_v2.sv
// rtl/ps2_mouse_master_sm_v2.sv - PS/2 mouse host FSM: init script, retries, packet decode and commit
module ps2_mouse_master_sm_v2 #(
    parameter int         INIT_WAIT_CYCLES    = 5000000,
    parameter int         RESP_TIMEOUT_CYCLES = 2500000,
    parameter int         MAX_RETRIES         = 3,
    parameter int         ENABLE_WHEEL        = 1,
    parameter logic [7:0] RESOLUTION          = 8'h02,
    parameter logic [7:0] SAMPLE_RATE         = 8'd100,
    parameter int         CNT_W               = 24
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic [7:0] MOUSE_DZ,
    output logic       SEND_INTERRUPT,
    output logic       WHEEL_MODE,
    output logic       INIT_DONE,
    output logic       INIT_FAIL,
    output logic [7:0] SYNC_ERR_COUNT
);

    localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESP_LAST   = CNT_W'(RESP_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);
    // Script step indices: 0 = FF, 1..7 = wheel unlock, 8..12 = E8 res F3 rate F4
    localparam logic [3:0]       STEP_ID     = 4'd7;
    localparam logic [3:0]       STEP_WHEEL_SKIP = 4'd8;
    localparam logic [3:0]       STEP_LAST   = 4'd12;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_SEND, S_WAIT_SENT, S_WAIT_RESP,
        S_PKT0, S_PKT1, S_PKT2, S_PKT3, S_FAIL
    } state_t;

    state_t           state;
    logic [1:0]       rst_pipe;
    logic [CNT_W-1:0] timer;
    logic [3:0]       step;
    logic [1:0]       resp_idx;
    logic [7:0]       retry_cnt;
    logic [7:0]       sh_status, sh_dx, sh_dy;
    logic             resp_ok, resp_last, step_fail;
    logic [7:0]       sync_next;
    logic             clean;

    function automatic logic [7:0] cmd_of(input logic [3:0] s);
        case (s)
            4'd0:    cmd_of = 8'hFF;
            4'd1:    cmd_of = 8'hF3;
            4'd2:    cmd_of = 8'hC8;
            4'd3:    cmd_of = 8'hF3;
            4'd4:    cmd_of = 8'h64;
            4'd5:    cmd_of = 8'hF3;
            4'd6:    cmd_of = 8'h50;
            4'd7:    cmd_of = 8'hF2;
            4'd8:    cmd_of = 8'hE8;
            4'd9:    cmd_of = RESOLUTION;
            4'd10:   cmd_of = 8'hF3;
            4'd11:   cmd_of = SAMPLE_RATE;
            default: cmd_of = 8'hF4;
        endcase
    endfunction

    // Release of reset is re-timed to CLK; assertion stays asynchronous
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end

    // Response checking and failure detection for the current init step
    always_comb begin
        clean     = (BYTE_ERROR_CODE == 2'b00);
        resp_ok   = 1'b0;
        resp_last = 1'b0;
        sync_next = (SYNC_ERR_COUNT == 8'hFF) ? 8'hFF : SYNC_ERR_COUNT + 8'd1;
        case (resp_idx)
            2'd0:    resp_ok = (BYTE_READ == 8'hFA);
            2'd1:    resp_ok = (step == 4'd0) ? (BYTE_READ == 8'hAA)
                                              : (BYTE_READ == 8'h03 || BYTE_READ == 8'h00);
            default: resp_ok = (BYTE_READ == 8'h00);
        endcase
        resp_ok = resp_ok && clean;
        if (step == 4'd0)         resp_last = (resp_idx == 2'd2);
        else if (step == STEP_ID) resp_last = (resp_idx == 2'd1);
        else                      resp_last = (resp_idx == 2'd0);
        step_fail = ((state == S_WAIT_SENT) && !BYTE_SENT && (timer == RESP_LAST)) ||
                    ((state == S_WAIT_RESP) && (BYTE_READY ? !resp_ok : (timer == RESP_LAST)));
    end

    // Main controller: init script, retry policy, packet assembly and atomic commit
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= S_INIT_WAIT;
            timer          <= '0;
            step           <= 4'd0;
            resp_idx       <= 2'd0;
            retry_cnt      <= 8'd0;
            sh_status      <= 8'd0;
            sh_dx          <= 8'd0;
            sh_dy          <= 8'd0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= 8'd0;
            READ_ENABLE    <= 1'b0;
            MOUSE_STATUS   <= 8'd0;
            MOUSE_DX       <= 8'd0;
            MOUSE_DY       <= 8'd0;
            MOUSE_DZ       <= 8'd0;
            SEND_INTERRUPT <= 1'b0;
            WHEEL_MODE     <= 1'b0;
            INIT_DONE      <= 1'b0;
            INIT_FAIL      <= 1'b0;
            SYNC_ERR_COUNT <= 8'd0;
        end else if (rst_pipe[1]) begin
            SEND_BYTE      <= 1'b0;
            SEND_INTERRUPT <= 1'b0;
            if (step_fail) begin
                READ_ENABLE <= 1'b0;
                timer       <= '0;
                if (retry_cnt + 8'd1 >= RETRY_LIMIT) begin
                    state     <= S_FAIL;
                    INIT_FAIL <= 1'b1;
                end else begin
                    retry_cnt  <= retry_cnt + 8'd1;
                    WHEEL_MODE <= 1'b0;
                    state      <= S_INIT_WAIT;
                end
            end else begin
                case (state)
                    S_INIT_WAIT: begin
                        WHEEL_MODE <= 1'b0;
                        if (timer == INIT_LAST) begin
                            timer <= '0;
                            step  <= 4'd0;
                            state <= S_SEND;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    S_SEND: begin
                        SEND_BYTE    <= 1'b1;
                        BYTE_TO_SEND <= cmd_of(step);
                        resp_idx     <= 2'd0;
                        timer        <= '0;
                        state        <= S_WAIT_SENT;
                    end
                    S_WAIT_SENT: begin
                        if (BYTE_SENT) begin
                            timer       <= '0;
                            READ_ENABLE <= 1'b1;
                            state       <= S_WAIT_RESP;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    S_WAIT_RESP: begin
                        if (BYTE_READY) begin
                            timer <= '0;
                            if (step == STEP_ID && resp_idx == 2'd1 && BYTE_READ == 8'h03)
                                WHEEL_MODE <= 1'b1;
                            if (!resp_last) begin
                                resp_idx <= resp_idx + 2'd1;
                            end else if (step == STEP_LAST) begin
                                INIT_DONE <= 1'b1;
                                retry_cnt <= 8'd0;
                                state     <= S_PKT0;
                            end else begin
                                READ_ENABLE <= 1'b0;
                                step  <= (step == 4'd0 && ENABLE_WHEEL == 0) ? STEP_WHEEL_SKIP
                                                                             : step + 4'd1;
                                state <= S_SEND;
                            end
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    S_PKT0: begin
                        if (BYTE_READY) begin
                            if (clean && BYTE_READ[3]) begin
                                sh_status <= BYTE_READ;
                                timer     <= '0;
                                state     <= S_PKT1;
                            end else begin
                                SYNC_ERR_COUNT <= sync_next;
                            end
                        end
                    end
                    S_PKT1, S_PKT2, S_PKT3: begin
                        if (BYTE_READY && !clean) begin
                            SYNC_ERR_COUNT <= sync_next;
                            state          <= S_PKT0;
                        end else if (BYTE_READY) begin
                            timer <= '0;
                            if (state == S_PKT1) begin
                                sh_dx <= BYTE_READ;
                                state <= S_PKT2;
                            end else if (state == S_PKT2 && WHEEL_MODE) begin
                                sh_dy <= BYTE_READ;
                                state <= S_PKT3;
                            end else begin
                                MOUSE_STATUS   <= sh_status;
                                MOUSE_DX       <= sh_dx;
                                MOUSE_DY       <= (state == S_PKT2) ? BYTE_READ : sh_dy;
                                MOUSE_DZ       <= (state == S_PKT3) ? BYTE_READ : 8'd0;
                                SEND_INTERRUPT <= 1'b1;
                                state          <= S_PKT0;
                            end
                        end else if (timer == RESP_LAST) begin
                            SYNC_ERR_COUNT <= sync_next;
                            state          <= S_PKT0;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    default: begin
                        READ_ENABLE <= 1'b0;
                        INIT_FAIL   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
